traffic_hs_sched: RTL and testbench

Clocked scheduler that sequences the traffic-light controller through its 4-phase request/acknowledge handshake. It arbitrates three command sources (emergency request, pedestrian request, periodic tick) and latches the sensor and mode fields into a stable command word. It drives the controller's left-side request, and it acknowledges the controller's right-side request as the downstream sink. It sits between the synchronous control domain and the self-timed traffic FSM stage.

---
 rtl/traffic_hs_sched.sv | 215 +++++++++++++++++++++
 tb/tb_traffic_hs_sched.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_hs_sched.sv
`timescale 1ns/1ps
// traffic_hs_sched
// Schedules 4-phase request/acknowledge transactions towards the self-timed
// traffic controller. Three command sources (emergency, pedestrian, periodic
// tick) are held as pending flags and granted with emg > ped > tick priority.
// Each grant latches a command word (sensor levels + mode) that stays stable
// until the next grant.
//
// Ports:
//   i_clk, i_rst             clock, synchronous active-high reset
//   i_traffic_a/b            road sensor levels, sampled at grant time
//   i_ped_req, i_emg_req     one-cycle request pulses
//   o_req / i_ack            left-side 4-phase handshake (i_ack async, 2-flop sync)
//   o_traffic_a/b, o_mode_p/r latched command fields
//   i_rreq / o_rack          right-side sink handshake mirror (i_rreq async)
//   o_grant                  source of current/last command (00 none, 01 tick, 10 ped, 11 emg)
//   o_busy                   any state other than IDLE
//   o_timeout                sticky: an ack phase waited TIMEOUT cycles
module traffic_hs_sched #(
  parameter int unsigned TICK_PERIOD = 50,
  parameter int unsigned TICK_W      = 8,
  parameter int unsigned TIMEOUT     = 255,
  parameter int unsigned TO_W        = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_traffic_a,
  input  logic       i_traffic_b,
  input  logic       i_ped_req,
  input  logic       i_emg_req,
  output logic       o_req,
  input  logic       i_ack,
  output logic       o_traffic_a,
  output logic       o_traffic_b,
  output logic       o_mode_p,
  output logic       o_mode_r,
  input  logic       i_rreq,
  output logic       o_rack,
  output logic [1:0] o_grant,
  output logic       o_busy,
  output logic       o_timeout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_REL,
    S_GAP
  } state_e;

  state_e            state_q;

  logic              ack_s1_q, ack_s2_q;
  logic              rreq_s1_q, rreq_s2_q;
  logic              rack_q;

  logic [TICK_W-1:0] tick_cnt_q;
  logic              tick_wrap;

  logic              emg_q, ped_q, tick_q;
  logic              emg_d, ped_d, tick_d;
  logic              clr_emg, clr_ped, clr_tick;
  logic              take;
  logic [1:0]        grant_d, mode_d;

  logic              req_q, busy_q, timeout_q;
  logic [1:0]        grant_q, mode_q;
  logic              ta_q, tb_q;
  logic [TO_W-1:0]   to_cnt_q;

  // Input synchronizers and the sink-side acknowledge mirror
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ack_s1_q  <= 1'b0;
      ack_s2_q  <= 1'b0;
      rreq_s1_q <= 1'b0;
      rreq_s2_q <= 1'b0;
      rack_q    <= 1'b0;
    end else begin
      ack_s1_q  <= i_ack;
      ack_s2_q  <= ack_s1_q;
      rreq_s1_q <= i_rreq;
      rreq_s2_q <= rreq_s1_q;
      rack_q    <= rreq_s2_q;
    end
  end

  // Free-running tick counter
  assign tick_wrap = (tick_cnt_q == TICK_W'(TICK_PERIOD - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tick_cnt_q <= '0;
    end else if (tick_wrap) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + TICK_W'(1);
    end
  end

  // Priority grant, only evaluated in IDLE
  always_comb begin
    grant_d  = 2'b00;
    mode_d   = 2'b00;
    clr_emg  = 1'b0;
    clr_ped  = 1'b0;
    clr_tick = 1'b0;
    if (state_q == S_IDLE) begin
      if (emg_q) begin
        grant_d = 2'b11;
        mode_d  = 2'b01;
        clr_emg = 1'b1;
      end else if (ped_q) begin
        grant_d = 2'b10;
        mode_d  = 2'b10;
        clr_ped = 1'b1;
      end else if (tick_q) begin
        grant_d  = 2'b01;
        mode_d   = 2'b00;
        clr_tick = 1'b1;
      end
    end
  end

  assign take = (state_q == S_IDLE) && (emg_q || ped_q || tick_q);

  // A new set in the same cycle as the grant keeps the flag pending
  assign emg_d  = i_emg_req | (emg_q  & ~clr_emg);
  assign ped_d  = i_ped_req | (ped_q  & ~clr_ped);
  assign tick_d = tick_wrap | (tick_q & ~clr_tick);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      emg_q  <= 1'b0;
      ped_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      emg_q  <= emg_d;
      ped_q  <= ped_d;
      tick_q <= tick_d;
    end
  end

  // Handshake FSM with registered outputs. A timeout only flags; the state
  // is held so the 4-phase protocol is never broken.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      req_q     <= 1'b0;
      busy_q    <= 1'b0;
      grant_q   <= '0;
      mode_q    <= '0;
      ta_q      <= 1'b0;
      tb_q      <= 1'b0;
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (take) begin
            state_q  <= S_REQ;
            req_q    <= 1'b1;
            busy_q   <= 1'b1;
            grant_q  <= grant_d;
            mode_q   <= mode_d;
            ta_q     <= i_traffic_a;
            tb_q     <= i_traffic_b;
            to_cnt_q <= '0;
          end
        end
        S_REQ: begin
          if (ack_s2_q) begin
            state_q  <= S_REL;
            req_q    <= 1'b0;
            to_cnt_q <= '0;
          end else begin
            if (to_cnt_q != TO_W'(TIMEOUT)) begin
              to_cnt_q <= to_cnt_q + TO_W'(1);
            end
            if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
              timeout_q <= 1'b1;
            end
          end
        end
        S_REL: begin
          if (!ack_s2_q) begin
            state_q <= S_GAP;
          end else begin
            if (to_cnt_q != TO_W'(TIMEOUT)) begin
              to_cnt_q <= to_cnt_q + TO_W'(1);
            end
            if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
              timeout_q <= 1'b1;
            end
          end
        end
        S_GAP: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_req       = req_q;
  assign o_busy      = busy_q;
  assign o_grant     = grant_q;
  assign o_mode_p    = mode_q[1];
  assign o_mode_r    = mode_q[0];
  assign o_traffic_a = ta_q;
  assign o_traffic_b = tb_q;
  assign o_timeout   = timeout_q;
  assign o_rack      = rack_q;

endmodule

// File: tb/tb_traffic_hs_sched.sv
`timescale 1ns/1ps
module tb_traffic_hs_sched;

  localparam int unsigned TP  = 1000;
  localparam int unsigned TW  = 10;
  localparam int unsigned TO  = 255;
  localparam int unsigned TOW = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       traffic_a, traffic_b, ped_req, emg_req, ack, rreq;
  logic       o_req, o_traffic_a, o_traffic_b, o_mode_p, o_mode_r, o_rack, o_busy, o_timeout;
  logic [1:0] o_grant;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0] g;
    logic [1:0] m;
    logic       ta;
    logic       tb;
  } cmd_t;

  cmd_t exp_q[$];
  cmd_t cur;
  logic req_prev = 1'b0;

  traffic_hs_sched #(
    .TICK_PERIOD(TP),
    .TICK_W     (TW),
    .TIMEOUT    (TO),
    .TO_W       (TOW)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_traffic_a(traffic_a),
    .i_traffic_b(traffic_b),
    .i_ped_req  (ped_req),
    .i_emg_req  (emg_req),
    .o_req      (o_req),
    .i_ack      (ack),
    .o_traffic_a(o_traffic_a),
    .o_traffic_b(o_traffic_b),
    .o_mode_p   (o_mode_p),
    .o_mode_r   (o_mode_r),
    .i_rreq     (rreq),
    .o_rack     (o_rack),
    .o_grant    (o_grant),
    .o_busy     (o_busy),
    .o_timeout  (o_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pack(input cmd_t c);
    return {26'd0, c.g, c.m, c.ta, c.tb};
  endfunction

  function automatic logic [31:0] dut_cmd();
    return {26'd0, o_grant, o_mode_p, o_mode_r, o_traffic_a, o_traffic_b};
  endfunction

  // Monitor: pop on each o_req rise, and re-check the held command on fall
  always @(negedge clk) begin
    if (!rst) begin
      if (o_req && !req_prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_req", 32'd1, 32'd0);
        end else begin
          cur = exp_q.pop_front();
          check("cmd_at_req", dut_cmd(), pack(cur));
        end
      end else if (!o_req && req_prev) begin
        check("cmd_held_at_release", dut_cmd(), pack(cur));
      end
    end
    req_prev = o_req;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [1:0] g, input logic [1:0] m, input logic ta, input logic tb);
    cmd_t c;
    c.g = g; c.m = m; c.ta = ta; c.tb = tb;
    exp_q.push_back(c);
  endtask

  task automatic wait_req(input string name, input int budget, output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (!o_req && n < budget);
    check({name, "_req_seen"}, o_req, 1'b1);
  endtask

  // Completes a handshake already in REQ; checks both 3-cycle sync latencies
  task automatic handshake(input string name);
    int n;
    step(3);
    ack = 1'b1;
    n = 0;
    do begin
      step(1);
      n++;
    end while (o_req && n < 20);
    check({name, "_ack_to_release"}, n, 3);
    ack = 1'b0;
    n = 0;
    do begin
      step(1);
      n++;
    end while (o_busy && n < 20);
    check({name, "_release_to_idle"}, n, 4);
  endtask

  task automatic pulse_emg();
    emg_req = 1'b1;
    step(1);
    emg_req = 1'b0;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int busy_seen;

    // Reset with random inputs
    rst = 1'b1;
    repeat (4) begin
      traffic_a = 1'($urandom); traffic_b = 1'($urandom);
      ped_req   = 1'($urandom); emg_req   = 1'($urandom);
      ack       = 1'($urandom); rreq      = 1'($urandom);
      step(1);
    end
    check("reset_outputs",
          {o_req, o_grant, o_mode_p, o_mode_r, o_traffic_a, o_traffic_b, o_rack, o_busy, o_timeout},
          '0);
    traffic_a = 1'b0; traffic_b = 1'b0; ped_req = 1'b0; emg_req = 1'b0;
    ack = 1'b0; rreq = 1'b0;
    step(1);

    // First tick: wrap at edge TP, grant at TP+1
    traffic_a = 1'b1; traffic_b = 1'b1;
    push(2'b01, 2'b00, 1'b1, 1'b1);
    rst = 1'b0;
    wait_req("tick", TP + 20, n);
    check("tick_first_req_edge", n, TP + 1);
    handshake("tick");

    // Emergency: o_req two edges after the pulse is sampled
    traffic_a = 1'b1; traffic_b = 1'b0;
    push(2'b11, 2'b01, 1'b1, 1'b0);
    emg_req = 1'b1;
    step(1);
    emg_req = 1'b0;
    check("emg_req_not_yet", o_req, 1'b0);
    step(1);
    check("emg_req_rise", {o_req, o_busy}, 2'b11);
    handshake("emg");

    // Priority: simultaneous emg + ped, emg first; inputs change mid-transaction
    push(2'b11, 2'b01, 1'b1, 1'b0);
    push(2'b10, 2'b10, 1'b0, 1'b1);
    emg_req = 1'b1; ped_req = 1'b1;
    step(1);
    emg_req = 1'b0; ped_req = 1'b0;
    wait_req("prio_emg", 10, n);
    traffic_a = 1'b0; traffic_b = 1'b1;
    handshake("prio_emg");
    wait_req("prio_ped", 10, n);
    check("prio_ped_gap", n, 1);
    handshake("prio_ped");

    // Ped pulse during an emg transaction is served afterwards
    traffic_a = 1'b1; traffic_b = 1'b1;
    push(2'b11, 2'b01, 1'b1, 1'b1);
    push(2'b10, 2'b10, 1'b0, 1'b0);
    pulse_emg();
    wait_req("late_emg", 10, n);
    ped_req = 1'b1;
    step(1);
    ped_req = 1'b0;
    traffic_a = 1'b0; traffic_b = 1'b0;
    handshake("late_emg");
    wait_req("late_ped", 10, n);
    handshake("late_ped");

    // Timeout: no ack for TIMEOUT cycles after REQ entry
    traffic_a = 1'b0; traffic_b = 1'b1;
    push(2'b11, 2'b01, 1'b0, 1'b1);
    pulse_emg();
    wait_req("to", 10, n);
    step(TO - 1);
    check("timeout_not_early", o_timeout, 1'b0);
    step(1);
    check("timeout_set", {o_timeout, o_req}, 2'b11);
    step(5);
    check("timeout_req_held", {o_timeout, o_req, o_busy}, 3'b111);
    handshake("to_late_ack");
    check("timeout_sticky", o_timeout, 1'b1);

    // Sink mirror while a master transaction sits in REQ
    traffic_a = 1'b1; traffic_b = 1'b0;
    push(2'b11, 2'b01, 1'b1, 1'b0);
    pulse_emg();
    wait_req("sink_bg", 10, n);
    rreq = 1'b1;
    step(2);
    check("rack_rise_not_early", o_rack, 1'b0);
    step(1);
    check("rack_rise", o_rack, 1'b1);
    rreq = 1'b0;
    step(2);
    check("rack_fall_not_early", o_rack, 1'b1);
    step(1);
    check("rack_fall", o_rack, 1'b0);
    handshake("sink_bg");

    // Reset during REQ with a pending ped flag
    traffic_a = 1'b1; traffic_b = 1'b1;
    push(2'b11, 2'b01, 1'b1, 1'b1);
    pulse_emg();
    wait_req("rst_mid", 10, n);
    ped_req = 1'b1;
    step(1);
    ped_req = 1'b0;
    rst = 1'b1;
    step(1);
    check("rst_mid_outputs",
          {o_req, o_busy, o_grant, o_mode_p, o_mode_r, o_traffic_a, o_traffic_b, o_timeout},
          '0);
    step(2);
    rst = 1'b0;
    busy_seen = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (o_busy || o_req) busy_seen++;
    end
    check("no_grant_after_rst", busy_seen, 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
